axis_event_arbiter: RTL and testbench

Packet-atomic round-robin arbiter that merges the AXI-Stream event outputs of several timestamping front-ends (digital input capture, counter channels) onto one AXI-Stream toward the DMA/FIFO path. Each forwarded packet gets a one-beat header carrying the source index, so downstream software can demultiplex. The block sits between the per-source event generators and the shared stream sink, in the `clk` domain.

---
 rtl/axis_event_arbiter.sv | 139 +++++++++++++
 tb/tb_axis_event_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_event_arbiter.sv
// Packet-atomic round-robin merge of N AXI-Stream event sources.
// Each forwarded packet is preceded by a one-beat source-index header.
module axis_event_arbiter #(
  parameter int          N_SOURCES          = 4,
  parameter int          C_AXIS_TDATA_WIDTH = 32,
  parameter logic [15:0] HEADER_MAGIC       = 16'hE5E5
) (
  input  logic                                    clk,
  input  logic                                    resetn,
  input  logic                                    run,
  input  logic [N_SOURCES-1:0]                    s_axis_tvalid,
  input  logic [N_SOURCES*C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [N_SOURCES-1:0]                    s_axis_tlast,
  output logic [N_SOURCES-1:0]                    s_axis_tready,
  output logic                                    m_axis_tvalid,
  output logic [C_AXIS_TDATA_WIDTH-1:0]           m_axis_tdata,
  output logic                                    m_axis_tlast,
  input  logic                                    m_axis_tready,
  output logic                                    busy,
  output logic [3:0]                              grant_id,
  output logic [31:0]                             packet_count
);

  localparam int W  = C_AXIS_TDATA_WIDTH;
  localparam int IW = (N_SOURCES > 1) ? $clog2(N_SOURCES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    DATA
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] gnt;
  logic [IW-1:0] pick;
  logic [IW-1:0] rr_nx;
  logic [IW:0]   idx;
  logic [IW:0]   nxt;
  logic          pick_vld;
  logic          grant_en;
  logic          beat_last;
  logic [W-1:0]  hdr;
  logic [W-1:0]  sdata [N_SOURCES];

  for (genvar i = 0; i < N_SOURCES; i++) begin : g_split
    assign sdata[i] = s_axis_tdata[i*W +: W];
  end

  // Scan downward so the nearest requester at or after rr_ptr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    idx      = '0;
    for (int k = N_SOURCES - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + (IW+1)'(k);
      if (idx >= (IW+1)'(N_SOURCES))
        idx = idx - (IW+1)'(N_SOURCES);
      if (s_axis_tvalid[idx[IW-1:0]]) begin
        pick_vld = 1'b1;
        pick     = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    nxt = {1'b0, pick} + (IW+1)'(1);
    if (nxt >= (IW+1)'(N_SOURCES))
      nxt = '0;
    rr_nx = nxt[IW-1:0];
  end

  assign grant_en  = (state == IDLE) && run && pick_vld;
  assign beat_last = s_axis_tvalid[gnt] & s_axis_tlast[gnt]
                   & m_axis_tready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (run && pick_vld) state_nx = HEADER;
      HEADER:  if (m_axis_tready)   state_nx = DATA;
      DATA:    if (beat_last)       state_nx = IDLE;
      default:                      state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr       <= '0;
      gnt          <= '0;
      packet_count <= '0;
    end else begin
      if (grant_en) begin
        gnt    <= pick;
        rr_ptr <= rr_nx;
      end
      if (state == DATA && beat_last)
        packet_count <= packet_count + 32'd1;
    end
  end

  always_comb begin
    hdr              = '0;
    hdr[W-1 -: 16]   = HEADER_MAGIC;
    hdr[3:0]         = grant_id;
  end

  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    unique case (state)
      HEADER: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = hdr;
      end
      DATA: begin
        m_axis_tvalid      = s_axis_tvalid[gnt];
        m_axis_tdata       = sdata[gnt];
        m_axis_tlast       = s_axis_tlast[gnt];
        s_axis_tready[gnt] = m_axis_tready;
      end
      default: ;
    endcase
  end

  assign busy     = (state != IDLE);
  assign grant_id = 4'(gnt);

endmodule

// File: tb/tb_axis_event_arbiter.sv
// Directed bench for axis_event_arbiter: vector table
// plus hand sequences for fairness, backpressure, run and reset.
module tb_axis_event_arbiter;

  logic         clk = 1'b0;
  logic         resetn;
  logic         run;
  logic [3:0]   s_tvalid;
  logic [127:0] s_tdata;
  logic [3:0]   s_tlast;
  logic [3:0]   s_tready;
  logic         m_tvalid;
  logic [31:0]  m_tdata;
  logic         m_tlast;
  logic         m_tready;
  logic         busy;
  logic [3:0]   grant_id;
  logic [31:0]  packet_count;

  axis_event_arbiter dut (
    .clk           (clk),
    .resetn        (resetn),
    .run           (run),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tdata  (s_tdata),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tdata  (m_tdata),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .busy          (busy),
    .grant_id      (grant_id),
    .packet_count  (packet_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         run;
    logic [3:0]   vld;
    logic [127:0] dat;
    logic [3:0]   lst;
    logic         rdy;
    logic         e_mv;
    logic [31:0]  e_md;
    logic         e_ml;
    logic [3:0]   e_sr;
    logic         e_busy;
    logic [3:0]   e_gid;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [127:0] dat4(input logic [31:0] a3,
      input logic [31:0] a2, input logic [31:0] a1,
      input logic [31:0] a0);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [63:0] snap();
    return {21'd0, m_tvalid, m_tdata, m_tlast, s_tready, busy, grant_id};
  endfunction

  function automatic logic [63:0] expv(input vec_t v);
    return {21'd0, v.e_mv, v.e_md, v.e_ml, v.e_sr, v.e_busy, v.e_gid};
  endfunction

  task automatic drive(input logic r, input logic [3:0] v,
                       input logic [127:0] d, input logic [3:0] l,
                       input logic k);
    run      = r;
    s_tvalid = v;
    s_tdata  = d;
    s_tlast  = l;
    m_tready = k;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  vec_t        tv [15];
  logic [127:0] d1a, d1b, d2, d03, d0;
  int          hid [4];
  int          hcyc [4];
  int          nh;
  logic [3:0]  acc;
  logic [31:0] bp [3];
  logic [31:0] bexp [4];
  logic [31:0] cap [$];
  logic [31:0] cv;
  int          b;
  logic        rk;

  initial begin
    d1a = dat4(32'h0, 32'h0, 32'h11, 32'h0);
    d1b = dat4(32'h0, 32'h0, 32'h22, 32'h0);
    d2  = dat4(32'h0, 32'h33, 32'h0, 32'h0);
    d03 = dat4(32'hD0, 32'h0, 32'h0, 32'hA0);
    d0  = dat4(32'h0, 32'h0, 32'h0, 32'hA0);
    tv[0]  = '{1'b1, 4'b0010, d1a, 4'b0000, 1'b1,
               1'b0, 32'h0, 1'b0, 4'b0000, 1'b0, 4'd0};
    tv[1]  = '{1'b1, 4'b0010, d1a, 4'b0000, 1'b1,
               1'b1, 32'hE5E50001, 1'b0, 4'b0000, 1'b1, 4'd1};
    tv[2]  = '{1'b1, 4'b0010, d1a, 4'b0000, 1'b1,
               1'b1, 32'h11, 1'b0, 4'b0010, 1'b1, 4'd1};
    tv[3]  = '{1'b1, 4'b0010, d1b, 4'b0010, 1'b1,
               1'b1, 32'h22, 1'b1, 4'b0010, 1'b1, 4'd1};
    tv[4]  = '{1'b1, 4'b0000, 128'd0, 4'b0000, 1'b1,
               1'b0, 32'h0, 1'b0, 4'b0000, 1'b0, 4'd1};
    tv[5]  = '{1'b1, 4'b0100, d2, 4'b0100, 1'b1,
               1'b0, 32'h0, 1'b0, 4'b0000, 1'b0, 4'd1};
    tv[6]  = '{1'b1, 4'b0100, d2, 4'b0100, 1'b1,
               1'b1, 32'hE5E50002, 1'b0, 4'b0000, 1'b1, 4'd2};
    tv[7]  = '{1'b1, 4'b0100, d2, 4'b0100, 1'b1,
               1'b1, 32'h33, 1'b1, 4'b0100, 1'b1, 4'd2};
    tv[8]  = '{1'b1, 4'b1001, d03, 4'b1001, 1'b1,
               1'b0, 32'h0, 1'b0, 4'b0000, 1'b0, 4'd2};
    tv[9]  = '{1'b1, 4'b1001, d03, 4'b1001, 1'b1,
               1'b1, 32'hE5E50003, 1'b0, 4'b0000, 1'b1, 4'd3};
    tv[10] = '{1'b1, 4'b1001, d03, 4'b1001, 1'b1,
               1'b1, 32'hD0, 1'b1, 4'b1000, 1'b1, 4'd3};
    tv[11] = '{1'b1, 4'b0001, d0, 4'b0001, 1'b1,
               1'b0, 32'h0, 1'b0, 4'b0000, 1'b0, 4'd3};
    tv[12] = '{1'b1, 4'b0001, d0, 4'b0001, 1'b1,
               1'b1, 32'hE5E50000, 1'b0, 4'b0000, 1'b1, 4'd0};
    tv[13] = '{1'b1, 4'b0001, d0, 4'b0001, 1'b1,
               1'b1, 32'hA0, 1'b1, 4'b0001, 1'b1, 4'd0};
    tv[14] = '{1'b1, 4'b0000, 128'd0, 4'b0000, 1'b1,
               1'b0, 32'h0, 1'b0, 4'b0000, 1'b0, 4'd0};

    // reset state
    resetn = 1'b0;
    drive(1'b0, 4'b0, 128'd0, 4'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", snap(), 64'd0);
    check("reset_pcnt", 64'(packet_count), 64'd0);
    resetn = 1'b1;

    // single packet, fairness after source 2
    for (int i = 0; i < 15; i++) begin
      drive(tv[i].run, tv[i].vld, tv[i].dat, tv[i].lst, tv[i].rdy);
      @(negedge clk);
      check($sformatf("vec%0d", i), snap(), expv(tv[i]));
      next_cycle();
    end
    check("table_pcnt", 64'(packet_count), 64'd4);

    // simultaneous one-beat requests from reset
    do_reset();
    drive(1'b1, 4'hF, dat4(32'h103, 32'h102, 32'h101, 32'h100),
          4'hF, 1'b1);
    nh = 0;
    for (int k = 0; k < 4; k++) begin
      hid[k]  = -1;
      hcyc[k] = -1;
    end
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (m_tvalid && busy && m_tdata[31:16] == 16'hE5E5
          && s_tready == 4'b0 && nh < 4) begin
        hid[nh]  = int'(m_tdata[3:0]);
        hcyc[nh] = c;
        nh++;
      end
      acc = s_tready & s_tvalid;
      next_cycle();
      s_tvalid = s_tvalid & ~acc;
    end
    check("sim_nhdr", 64'(nh), 64'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("sim_id%0d", k), 64'(hid[k]), 64'(k));
      check($sformatf("sim_cyc%0d", k), 64'(hcyc[k]), 64'(1 + 3*k));
    end
    check("sim_pcnt", 64'(packet_count), 64'd4);

    // backpressure on header and payload, source 2
    bp[0] = 32'h201;
    bp[1] = 32'h202;
    bp[2] = 32'h203;
    b = 0;
    for (int c = 0; c < 14; c++) begin
      rk = (c == 6) || (c >= 10);
      drive(1'b1, (b < 3) ? 4'b0100 : 4'b0000,
            dat4(32'h0, bp[(b < 3) ? b : 2], 32'h0, 32'h0),
            (b == 2) ? 4'b0100 : 4'b0000, rk);
      @(negedge clk);
      if (c >= 1 && cap.size() == 0)
        check("hdr_hold", {27'd0, m_tvalid, s_tready, m_tdata},
              {27'd0, 1'b1, 4'b0000, 32'hE5E50002});
      else if (c >= 7 && busy)
        check("sready_mirror", 64'(s_tready),
              rk ? 64'd4 : 64'd0);
      if (m_tvalid && m_tready)
        cap.push_back(m_tdata);
      if (s_tready[2] && s_tvalid[2])
        b++;
      next_cycle();
    end
    bexp[0] = 32'hE5E50002;
    bexp[1] = 32'h201;
    bexp[2] = 32'h202;
    bexp[3] = 32'h203;
    check("bp_nbeats", 64'(cap.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      cv = (k < cap.size()) ? cap[k] : 32'hxxxxxxxx;
      check($sformatf("bp_beat%0d", k), 64'(cv), 64'(bexp[k]));
    end
    check("bp_pcnt", 64'(packet_count), 64'd5);

    // run dropped mid-packet of source 0
    drive(1'b1, 4'b0001, dat4(32'h0, 32'h0, 32'h0, 32'h301),
          4'b0000, 1'b1);
    next_cycle();
    drive(1'b0, 4'b0011, dat4(32'h0, 32'h0, 32'h401, 32'h301),
          4'b0000, 1'b1);
    @(negedge clk);
    check("gate_hdr0", {31'd0, m_tvalid, m_tdata},
          {31'd0, 1'b1, 32'hE5E50000});
    next_cycle();
    @(negedge clk);
    check("gate_d0", 64'(m_tdata), 64'h301);
    next_cycle();
    drive(1'b0, 4'b0011, dat4(32'h0, 32'h0, 32'h401, 32'h302),
          4'b0001, 1'b1);
    @(negedge clk);
    check("gate_d1", {31'd0, m_tlast, m_tdata},
          {31'd0, 1'b1, 32'h302});
    next_cycle();
    drive(1'b0, 4'b0010, dat4(32'h0, 32'h0, 32'h401, 32'h0),
          4'b0000, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("gate_hold%0d", c), {62'd0, m_tvalid, busy},
            64'd0);
      next_cycle();
    end
    check("gate_pcnt", 64'(packet_count), 64'd6);
    run = 1'b1;
    @(negedge clk);
    check("gate_idle", 64'(busy), 64'd0);
    next_cycle();
    @(negedge clk);
    check("gate_hdr1", {31'd0, m_tvalid, m_tdata},
          {31'd0, 1'b1, 32'hE5E50001});
    next_cycle();
    @(negedge clk);
    check("gate_d401", 64'(m_tdata), 64'h401);

    // asynchronous reset during DATA
    #1;
    resetn = 1'b0;
    #1;
    check("async_outs", snap(), 64'd0);
    check("async_pcnt", 64'(packet_count), 64'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    drive(1'b1, 4'b1010, dat4(32'h601, 32'h0, 32'h501, 32'h0),
          4'b1010, 1'b1);
    @(negedge clk);
    check("rst_idle", 64'(busy), 64'd0);
    next_cycle();
    @(negedge clk);
    check("rr_restart", {31'd0, m_tvalid, m_tdata},
          {31'd0, 1'b1, 32'hE5E50001});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
